// File: rtl/seg7_scan_driver_if.sv
// Request/status bundle between the display requester (master) and the scan driver (slave).
// The master presents display content plus a load request; the slave returns pins and pulses.
interface seg7_scan_driver_if #(
  parameter int DIGITS   = 6,
  parameter int PWM_BITS = 3
);
  logic [4*DIGITS-1:0] data_in;
  logic [DIGITS-1:0]   dot_mask;
  logic [DIGITS-1:0]   blink_mask;
  logic                blank_lead;
  logic [PWM_BITS-1:0] brightness;
  logic                load;
  logic                load_ack;
  logic                frame_tick;
  logic [7:0]          LED_code;
  logic [DIGITS-1:0]   LED_index;

  modport master (
    output data_in, dot_mask, blink_mask, blank_lead, brightness, load,
    input  load_ack, frame_tick, LED_code, LED_index
  );

  modport slave (
    input  data_in, dot_mask, blink_mask, blank_lead, brightness, load,
    output load_ack, frame_tick, LED_code, LED_index
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with PWM brightness, blink,
// leading-zero suppression and a frame-aligned (tear-free) load handshake.
module seg7_scan_driver #(
  parameter int DIGITS     = 6,
  parameter int DIV_BITS   = 16,
  parameter int PWM_BITS   = 3,
  parameter int BLINK_BITS = 5
) (
  input  logic CLK,
  input  logic RST_n,
  seg7_scan_driver_if.slave bus
);

  localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PTR_W-1:0] LAST_DIGIT = PTR_W'(DIGITS - 1);

  logic [DIV_BITS-1:0]   slot;
  logic [PTR_W-1:0]      digit;
  logic [BLINK_BITS-1:0] frame_cnt;
  logic                  blink_phase;

  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_dot;
  logic [DIGITS-1:0]   sh_blink;
  logic                sh_blank;
  logic [PWM_BITS-1:0] sh_bright;

  logic              slot_wrap;
  logic              frame_end;
  logic [3:0]        nib;
  logic              dot_sel;
  logic              blink_sel;
  logic              supp_sel;
  logic              run;
  logic              pwm_ok;
  logic              lit;
  logic [DIGITS-1:0] idx_lit;

  logic [7:0]        code_q;
  logic [DIGITS-1:0] index_q;
  logic              ack_q;
  logic              tick_q;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: seg_of = 7'b0000001;
      4'h1: seg_of = 7'b1001111;
      4'h2: seg_of = 7'b0010010;
      4'h3: seg_of = 7'b0000110;
      4'h4: seg_of = 7'b1001100;
      4'h5: seg_of = 7'b0100100;
      4'h6: seg_of = 7'b0100000;
      4'h7: seg_of = 7'b0001111;
      4'h8: seg_of = 7'b0000000;
      4'h9: seg_of = 7'b0000100;
      4'hA: seg_of = 7'b0001000;
      4'hB: seg_of = 7'b1100000;
      4'hC: seg_of = 7'b0110001;
      4'hD: seg_of = 7'b1000010;
      4'hE: seg_of = 7'b0110000;
      default: seg_of = 7'b0111000;
    endcase
  endfunction

  assign slot_wrap = &slot;
  assign frame_end = slot_wrap && (digit == LAST_DIGIT);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      slot        <= '0;
      digit       <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      slot <= slot + 1'b1;
      if (slot_wrap) begin
        digit <= (digit == LAST_DIGIT) ? '0 : digit + 1'b1;
      end
      if (frame_end) begin
        frame_cnt <= frame_cnt + 1'b1;
        if (&frame_cnt) begin
          blink_phase <= ~blink_phase;
        end
      end
    end
  end

  // Shadows only change on the frame-end edge, so a frame never mixes old and new content.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sh_data   <= '0;
      sh_dot    <= '0;
      sh_blink  <= '0;
      sh_blank  <= 1'b0;
      sh_bright <= '1;
    end else if (frame_end && bus.load) begin
      sh_data   <= bus.data_in;
      sh_dot    <= bus.dot_mask;
      sh_blink  <= bus.blink_mask;
      sh_blank  <= bus.blank_lead;
      sh_bright <= bus.brightness;
    end
  end

  // Walk from the top digit down so run means "this nibble and all above it are zero".
  always_comb begin
    nib       = 4'h0;
    dot_sel   = 1'b0;
    blink_sel = 1'b0;
    supp_sel  = 1'b0;
    run       = 1'b1;
    idx_lit   = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run = run & (sh_data[i*4 +: 4] == 4'h0);
      if (digit == i[PTR_W-1:0]) begin
        nib        = sh_data[i*4 +: 4];
        dot_sel    = sh_dot[i];
        blink_sel  = sh_blink[i];
        supp_sel   = run && (i != 0);
        idx_lit[i] = 1'b0;
      end
    end
    pwm_ok = slot[DIV_BITS-1 -: PWM_BITS] <= sh_bright;
    lit    = pwm_ok && !(blink_sel && blink_phase) && !(sh_blank && supp_sel);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      code_q  <= 8'hFF;
      index_q <= '1;
      ack_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= frame_end;
      ack_q  <= frame_end && bus.load;
      if (lit) begin
        code_q  <= {seg_of(nib), ~dot_sel};
        index_q <= idx_lit;
      end else begin
        code_q  <= 8'hFF;
        index_q <= '1;
      end
    end
  end

  assign bus.LED_code   = code_q;
  assign bus.LED_index  = index_q;
  assign bus.load_ack   = ack_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised bench for seg7_scan_driver: a cycle-indexed behavioural model predicts
// every registered output, and a few hand-computed checks pin that model down.
module tb_seg7_scan_driver;

  localparam int DIGITS     = 6;
  localparam int DIV_BITS   = 4;
  localparam int PWM_BITS   = 2;
  localparam int BLINK_BITS = 1;
  localparam int SLOT_LEN   = 1 << DIV_BITS;
  localparam int FRAME_LEN  = SLOT_LEN * DIGITS;
  localparam int PWM_STEP   = 1 << (DIV_BITS - PWM_BITS);

  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  seg7_scan_driver_if #(.DIGITS(DIGITS), .PWM_BITS(PWM_BITS)) bus ();

  seg7_scan_driver #(
    .DIGITS(DIGITS), .DIV_BITS(DIV_BITS), .PWM_BITS(PWM_BITS), .BLINK_BITS(BLINK_BITS)
  ) dut (
    .CLK(clk),
    .RST_n(rst_n),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else passes++;
  endtask

  // Model state: cycles since reset release plus the shadow content in force.
  int                  mc = 0;
  logic [4*DIGITS-1:0] m_data = '0;
  logic [DIGITS-1:0]   m_dot = '0;
  logic [DIGITS-1:0]   m_blink = '0;
  logic                m_blank = 1'b0;
  logic [PWM_BITS-1:0] m_bright = '1;
  logic [7:0]          exp_code = 8'hFF;
  logic [DIGITS-1:0]   exp_index = '1;
  logic                exp_ack = 1'b0;
  logic                exp_tick = 1'b0;

  function automatic logic [7+DIGITS:0] modelOut(
    input int c, input logic [4*DIGITS-1:0] d, input logic [DIGITS-1:0] dm,
    input logic [DIGITS-1:0] bm, input logic bl, input logic [PWM_BITS-1:0] br);
    int slot, dig, frame;
    logic on;
    logic [4*DIGITS-1:0] hi;
    logic [DIGITS-1:0] onehot;
    slot  = c % SLOT_LEN;
    dig   = (c / SLOT_LEN) % DIGITS;
    frame = c / FRAME_LEN;
    hi    = d >> (4 * dig);
    on    = (slot / PWM_STEP) <= int'(br);
    if (bm[dig] && (((frame >> BLINK_BITS) % 2) == 1)) on = 1'b0;
    if (bl && dig > 0 && hi == '0) on = 1'b0;
    onehot = '0;
    onehot[dig] = 1'b1;
    if (on) return {SEG[hi[3:0]], ~dm[dig], ~onehot};
    return {8'hFF, {DIGITS{1'b1}}};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc        <= 0;
      m_data    <= '0;
      m_dot     <= '0;
      m_blink   <= '0;
      m_blank   <= 1'b0;
      m_bright  <= '1;
      exp_code  <= 8'hFF;
      exp_index <= '1;
      exp_ack   <= 1'b0;
      exp_tick  <= 1'b0;
    end else begin
      {exp_code, exp_index} <= modelOut(mc, m_data, m_dot, m_blink, m_blank, m_bright);
      exp_tick <= (mc % FRAME_LEN) == FRAME_LEN - 1;
      exp_ack  <= ((mc % FRAME_LEN) == FRAME_LEN - 1) && bus.load;
      if (((mc % FRAME_LEN) == FRAME_LEN - 1) && bus.load) begin
        m_data   <= bus.data_in;
        m_dot    <= bus.dot_mask;
        m_blink  <= bus.blink_mask;
        m_blank  <= bus.blank_lead;
        m_bright <= bus.brightness;
      end
      mc <= mc + 1;
    end
  end

  always @(negedge clk) begin
    checkOutput("LED_code", 32'(bus.LED_code), 32'(exp_code));
    checkOutput("LED_index", 32'(bus.LED_index), 32'(exp_index));
    checkOutput("load_ack", 32'(bus.load_ack), 32'(exp_ack));
    checkOutput("frame_tick", 32'(bus.frame_tick), 32'(exp_tick));
  end

  task automatic applyStimulus(input logic [4*DIGITS-1:0] d, input logic [DIGITS-1:0] dm,
                               input logic [DIGITS-1:0] bm, input logic bl,
                               input logic [PWM_BITS-1:0] br);
    bit seen = 1'b0;
    @(negedge clk);
    bus.data_in    = d;
    bus.dot_mask   = dm;
    bus.blink_mask = bm;
    bus.blank_lead = bl;
    bus.brightness = br;
    bus.load       = 1'b1;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      @(negedge clk);
      if (bus.load_ack) begin
        seen = 1'b1;
        break;
      end
    end
    bus.load = 1'b0;
    if (!seen) checkOutput("load_ack_timeout", 0, 1);
  endtask

  task automatic waitTick(output int t);
    t = -1;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      @(negedge clk);
      if (bus.frame_tick) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) checkOutput("frame_tick_timeout", 0, 1);
  endtask

  initial begin
    int t1, t2, cnt, f0, f1;
    logic lit0, lit1;
    rst_n          = 1'b0;
    bus.data_in    = '0;
    bus.dot_mask   = '0;
    bus.blink_mask = '0;
    bus.blank_lead = 1'b0;
    bus.brightness = '1;
    bus.load       = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    checkOutput("post_reset_index", 32'(bus.LED_index), 32'(6'b111110));
    checkOutput("post_reset_code", 32'(bus.LED_code), 32'(8'b00000011));

    waitTick(t1);
    waitTick(t2);
    checkOutput("tick_spacing", 32'(t2 - t1), 32'(FRAME_LEN));

    repeat (30) @(negedge clk);
    applyStimulus(24'h12AB0F, 6'b000000, 6'b000000, 1'b0, 2'd3);
    @(negedge clk);
    checkOutput("load_digit0_code", 32'(bus.LED_code), 32'(8'b01110001));
    checkOutput("load_digit0_index", 32'(bus.LED_index), 32'(6'b111110));
    repeat (SLOT_LEN) @(negedge clk);
    checkOutput("load_digit1_code", 32'(bus.LED_code), 32'(8'b00000011));
    checkOutput("load_digit1_index", 32'(bus.LED_index), 32'(6'b111101));

    applyStimulus(24'h000050, 6'b000000, 6'b000000, 1'b1, 2'd3);
    @(negedge clk);
    checkOutput("supp_digit0_code", 32'(bus.LED_code), 32'(8'b00000011));
    repeat (SLOT_LEN) @(negedge clk);
    checkOutput("supp_digit1_code", 32'(bus.LED_code), 32'(8'b01001001));
    checkOutput("supp_digit1_index", 32'(bus.LED_index), 32'(6'b111101));
    repeat (SLOT_LEN) @(negedge clk);
    checkOutput("supp_digit2_code", 32'(bus.LED_code), 32'(8'hFF));
    checkOutput("supp_digit2_index", 32'(bus.LED_index), 32'(6'b111111));

    for (int b = 0; b < 4; b += 3) begin
      applyStimulus(24'h12AB0F, 6'b000000, 6'b000000, 1'b0, PWM_BITS'(b));
      cnt = 0;
      repeat (SLOT_LEN) begin
        @(negedge clk);
        if (!bus.LED_index[0]) cnt++;
      end
      checkOutput(b == 0 ? "pwm_duty_min" : "pwm_duty_max", 32'(cnt), b == 0 ? 32'd4 : 32'd16);
    end

    applyStimulus(24'h123456, 6'b000000, 6'b000001, 1'b0, 2'd3);
    f0 = 0;
    f1 = 0;
    repeat (4) begin
      lit0 = 1'b0;
      lit1 = 1'b0;
      repeat (FRAME_LEN) begin
        @(negedge clk);
        if (!bus.LED_index[0]) lit0 = 1'b1;
        if (!bus.LED_index[1]) lit1 = 1'b1;
      end
      f0 += int'(lit0);
      f1 += int'(lit1);
    end
    checkOutput("blink_digit0_lit_frames", 32'(f0), 32'd2);
    checkOutput("blink_digit1_lit_frames", 32'(f1), 32'd4);

    for (int r = 0; r < 10; r++) begin
      applyStimulus(24'($urandom) >> (4 * $urandom_range(0, 6)), 6'($urandom), 6'($urandom),
                    1'($urandom), 2'($urandom));
      if (r % 3 == 0) begin
        repeat ($urandom_range(5, 60)) @(negedge clk);
        bus.data_in    = 24'($urandom);
        bus.blank_lead = 1'($urandom);
        bus.brightness = 2'($urandom);
      end
      repeat (2 * FRAME_LEN) @(negedge clk);
    end

    waitTick(t1);
    bus.data_in = 24'hFEDCBA;
    bus.load    = 1'b1;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_code", 32'(bus.LED_code), 32'(8'hFF));
    checkOutput("reset_index", 32'(bus.LED_index), 32'(6'b111111));
    checkOutput("reset_ack", 32'(bus.load_ack), 32'd0);
    checkOutput("reset_tick", 32'(bus.frame_tick), 32'd0);
    repeat (3) @(negedge clk);
    bus.load = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    checkOutput("rerelease_index", 32'(bus.LED_index), 32'(6'b111110));
    checkOutput("rerelease_code", 32'(bus.LED_code), 32'(8'b00000011));
    repeat (FRAME_LEN + 4) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
